// File: rtl/fdiv_bank.sv
// -----------------------------------------------------------------------------
// fdiv_bank - multi-channel programmable frequency divider
//
// Each of CH channels divides fin by its own run-time divisor N and drives a
// low-then-high output: N-H cycles low followed by H cycles high. Divisor and
// high length are captured into shadow registers only at a period boundary,
// so an output never changes shape mid-period.
//
// Optional feature macro: FDIV_DUTY_EN
//   defined   : high length H = min(duty, N_eff), taken from the duty port
//   undefined : duty is ignored, H = N_eff - (N_eff >> 1)
//
// Parameters
//   WIDTH : counter / divisor / duty width in bits
//   CH    : number of independent channels
//
// Ports
//   fin   in  1         sole clock, rising edge
//   rst_n in  1         asynchronous active-low reset
//   en    in  CH        per-channel run enable
//   divn  in  CH*WIDTH  per-channel divisor, channel i at [i*WIDTH +: WIDTH]
//   duty  in  CH*WIDTH  per-channel high length, same packing
//   fout  out CH        divided outputs, registered
//   tick  out CH        one-cycle pulse at the start of each period, registered
// -----------------------------------------------------------------------------
module fdiv_bank #(
   parameter int WIDTH = 32,
   parameter int CH    = 4
) (
   input  logic                fin,
   input  logic                rst_n,
   input  logic [CH-1:0]       en,
   input  logic [CH*WIDTH-1:0] divn,
   input  logic [CH*WIDTH-1:0] duty,
   output logic [CH-1:0]       fout,
   output logic [CH-1:0]       tick
);

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

`ifndef FDIV_DUTY_EN
   // duty has no function in this build; the reduction feeds nothing and is
   // trimmed away, it only marks the port as intentionally unused.
   logic unused_duty;
   assign unused_duty = ^duty;
`endif

   for (genvar i = 0; i < CH; i++) begin : g_ch
      logic [WIDTH-1:0] n_in;
      logic [WIDTH-1:0] n_eff;
      logic [WIDTH-1:0] h_eff;
      logic [WIDTH-1:0] count;
      logic [WIDTH-1:0] n_a;
      logic [WIDTH-1:0] h_a;
      logic             fout_r;
      logic             tick_r;
      state_t           state;

      assign n_in  = divn[i*WIDTH +: WIDTH];
      // A divisor of 0 behaves as 1.
      assign n_eff = (n_in == '0) ? WIDTH'(1) : n_in;

`ifdef FDIV_DUTY_EN
      logic [WIDTH-1:0] d_in;
      assign d_in  = duty[i*WIDTH +: WIDTH];
      // Clamping to N keeps n_a - h_a from underflowing.
      assign h_eff = (d_in < n_eff) ? d_in : n_eff;
`else
      // Odd N puts the extra cycle in the high phase.
      assign h_eff = n_eff - (n_eff >> 1);
`endif

      always_ff @(posedge fin or negedge rst_n) begin
         if (!rst_n) begin
            state  <= IDLE;
            count  <= '0;
            n_a    <= WIDTH'(1);
            h_a    <= '0;
            fout_r <= 1'b0;
            tick_r <= 1'b0;
         end else begin
            // NOTE: non-blocking assignments make every branch below see the
            // pre-edge count/n_a/h_a, which the output rule depends on.
            case (state)
               IDLE: begin
                  fout_r <= 1'b0;
                  if (en[i]) begin
                     state  <= RUN;
                     n_a    <= n_eff;
                     h_a    <= h_eff;
                     count  <= WIDTH'(1);
                     tick_r <= 1'b1;
                  end else begin
                     count  <= '0;
                     tick_r <= 1'b0;
                  end
               end
               RUN: begin
                  if (!en[i]) begin
                     // Abandon the partial period; en low beats a wrap.
                     state  <= IDLE;
                     count  <= '0;
                     fout_r <= 1'b0;
                     tick_r <= 1'b0;
                  end else begin
                     fout_r <= (count > (n_a - h_a));
                     if (count >= n_a) begin
                        // Period boundary: the only point new settings land.
                        count  <= WIDTH'(1);
                        n_a    <= n_eff;
                        h_a    <= h_eff;
                        tick_r <= 1'b1;
                     end else begin
                        count  <= count + WIDTH'(1);
                        tick_r <= 1'b0;
                     end
                  end
               end
               default: begin
                  state  <= IDLE;
                  count  <= '0;
                  fout_r <= 1'b0;
                  tick_r <= 1'b0;
               end
            endcase
         end
      end

      assign fout[i] = fout_r;
      assign tick[i] = tick_r;
   end

endmodule

// File: tb/tb_fdiv_bank.sv
// -----------------------------------------------------------------------------
// tb_fdiv_bank - scoreboard bench for fdiv_bank (WIDTH=32, CH=4)
//
// The stimulus process pushes hand-written per-edge expectations for fout and
// tick into a queue, tagged with the fin edge after which they must hold. A
// separate monitor samples on the falling edge and retires matching entries.
// Asynchronous-reset checks are requested through the probe strobe.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_fdiv_bank;

   localparam int W  = 32;
   localparam int CH = 4;

   typedef struct {
      int    cyc;
      int    ch;
      logic  f;
      logic  t;
      string name;
   } exp_t;

   logic              fin;
   logic              rst_n;
   logic [CH-1:0]     en;
   logic [CH*W-1:0]   divn;
   logic [CH*W-1:0]   duty;
   logic [CH-1:0]     fout;
   logic [CH-1:0]     tick;

   logic              probe;
   logic              done;
   string             probe_name;
   int                edge_cnt = 0;
   int                n_checks = 0;
   int                n_fail   = 0;
   exp_t              sb[$];

   fdiv_bank #(.WIDTH(W), .CH(CH)) dut (
      .fin   (fin),
      .rst_n (rst_n),
      .en    (en),
      .divn  (divn),
      .duty  (duty),
      .fout  (fout),
      .tick  (tick)
   );

   initial fin = 1'b0;
   always #5 fin = ~fin;

   always @(posedge fin) edge_cnt <= edge_cnt + 1;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached, got no end, required end");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // ------------------------------------------------------------ monitor
   initial begin
      forever begin
         @(negedge fin or posedge probe or posedge done);
         if (done) begin
            check("sb_drained", sb.size(), 0);
            $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
            $finish;
         end else if (probe) begin
            check({probe_name, "_fout"}, 32'(fout), 0);
            check({probe_name, "_tick"}, 32'(tick), 0);
         end else begin
            for (int i = sb.size() - 1; i >= 0; i--) begin
               if (sb[i].cyc == edge_cnt) begin
                  check($sformatf("%s_ch%0d_e%0d_fout", sb[i].name, sb[i].ch, sb[i].cyc),
                        32'(fout[sb[i].ch]), 32'(sb[i].f));
                  check($sformatf("%s_ch%0d_e%0d_tick", sb[i].name, sb[i].ch, sb[i].cyc),
                        32'(tick[sb[i].ch]), 32'(sb[i].t));
                  sb.delete(i);
               end
            end
         end
      end
   end

   // ------------------------------------------------------------ helpers
   task automatic step();
      @(posedge fin);
      #1;
   endtask

   function automatic logic [W-1:0] dval(input logic [W-1:0] h);
`ifdef FDIV_DUTY_EN
      return h;
`else
      return '0;
`endif
   endfunction

   task automatic set_ch(input int ch, input logic [W-1:0] n, input logic [W-1:0] h);
      divn[ch*W +: W] = n;
      duty[ch*W +: W] = dval(h);
   endtask

   // Character j of fs/ts is the value expected after edge k+j.
   task automatic expect_ch(input int ch, input int k, input string fs, input string ts,
                            input string name);
      exp_t e;
      for (int i = 0; i < fs.len(); i++) begin
         e.cyc  = k + i;
         e.ch   = ch;
         e.f    = (fs[i] == "1");
         e.t    = (ts[i] == "1");
         e.name = name;
         sb.push_back(e);
      end
   endtask

   task automatic expect_zero(input int k, input int n, input string name);
      string z;
      z = "";
      for (int i = 0; i < n; i++) z = {z, "0"};
      for (int c = 0; c < CH; c++) expect_ch(c, k, z, z, name);
   endtask

   task automatic pulse_probe(input string name);
      probe_name = name;
      probe = 1'b1;
      #1;
      probe = 1'b0;
   endtask

   // ------------------------------------------------------------ stimulus
   initial begin
      int k;
      rst_n = 1'b0;
      en    = '0;
      divn  = '0;
      duty  = '0;
      probe = 1'b0;
      done  = 1'b0;

      // Reset state, then idle with en low.
      repeat (2) step();
      pulse_probe("reset_state");
      rst_n = 1'b1;
      expect_zero(edge_cnt + 1, 2, "idle");
      repeat (2) step();

      // N=4, N=0, N=1 and odd N=5 side by side.
      set_ch(0, 4, 2);
      set_ch(1, 0, 1);
      set_ch(2, 1, 1);
      set_ch(3, 5, 3);
      en = 4'hF;
      k  = edge_cnt + 1;
      expect_ch(0, k, "0001100110", "1000100010", "n4");
      expect_ch(1, k, "0111111111", "1111111111", "n0");
      expect_ch(2, k, "0111111111", "1111111111", "n1");
      expect_ch(3, k, "0001110011", "1000010000", "n5");
      repeat (10) step();
      en = '0;
      expect_zero(k + 10, 2, "stop_a");
      repeat (2) step();

      // en dropped at count=2 of N=6, then re-raised.
      set_ch(0, 6, 3);
      en = 4'b0001;
      k  = edge_cnt + 1;
      expect_ch(0, k, "0000000111", "1001000001", "en_drop");
      repeat (2) step();
      en[0] = 1'b0;
      step();
      en[0] = 1'b1;
      repeat (7) step();
      en = '0;
      expect_zero(k + 10, 2, "stop_b");
      repeat (2) step();

      // N=8 running, divisor changed to 5 while count=3.
      set_ch(1, 8, 4);
      en = 4'b0010;
      k  = edge_cnt + 1;
      expect_ch(1, k, "00000111100111001110", "10000000100001000010", "div_change");
      repeat (3) step();
      set_ch(1, 5, 3);
      repeat (17) step();
      en = '0;
      expect_zero(k + 20, 2, "stop_c");
      repeat (2) step();

`ifdef FDIV_DUTY_EN
      // Programmable high time, and a duty larger than N.
      set_ch(2, 10, 3);
      set_ch(3, 10, 20);
      en = 4'b1100;
      k  = edge_cnt + 1;
      expect_ch(2, k, "000000001110000", "100000000010000", "duty3");
      expect_ch(3, k, "011111111111111", "100000000010000", "duty20");
      repeat (15) step();
      en = '0;
      expect_zero(k + 15, 2, "stop_d");
      repeat (2) step();
`endif

      // Asynchronous reset mid-run on four different divisors.
      set_ch(0, 3, 2);
      set_ch(1, 4, 2);
      set_ch(2, 5, 3);
      set_ch(3, 7, 4);
      en = 4'hF;
      repeat (5) step();
      rst_n = 1'b0;
      #1;
      pulse_probe("async_rst");
      expect_zero(edge_cnt + 1, 1, "in_rst");
      step();
      rst_n = 1'b1;
      k = edge_cnt + 1;
      expect_ch(0, k, "0011011011", "1001001001", "rst_n3");
      expect_ch(1, k, "0001100110", "1000100010", "rst_n4");
      expect_ch(2, k, "0001110011", "1000010000", "rst_n5");
      expect_ch(3, k, "0000111100", "1000000100", "rst_n7");
      repeat (10) step();
      en = '0;
      expect_zero(k + 10, 2, "stop_e");
      repeat (3) step();

      done = 1'b1;
   end

endmodule
